calc_sequencer: RTL and testbench

//  Moore control FSM that drives the Calculations datapath of the 16-bit multi-cycle CPU, one micro-step per clock.

---
 rtl/calc_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: Moore control FSM for the 16-bit multi-cycle CPU datapath.
// Decodes the IR opcode and issues one micro-step of datapath control per clock,
// waiting on the memory handshake in FETCH, MEM_RD and MEM_WR.
//
// Ports:
//   clk, reset (async, active-low)
//   input_opcode         IR[15:12], stable from DECODE until the instruction retires
//   input_Zero           ALU zero flag, used only by BRANCH
//   input_mem_ready      memory completes the current access this cycle
//   output_ALUOp/ALUSrcA/ALUSrcB/PCSrc     datapath selects
//   output_PCWrite/IRWrite/MemRead/MemWrite/IorD/RegWrite/MemtoReg  enables
//   output_halted/illegal                  sticky stop indications
//   output_state                           current state encoding
//   output_instr_count                     retired-instruction count
//
// Optional feature: define INSTR_COUNT_EN to build the retired-instruction
// counter; otherwise output_instr_count is tied to 0.
module calc_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       input_opcode,
  input  logic             input_Zero,
  input  logic             input_mem_ready,
  output logic [3:0]       output_ALUOp,
  output logic [1:0]       output_ALUSrcA,
  output logic [1:0]       output_ALUSrcB,
  output logic             output_PCSrc,
  output logic             output_PCWrite,
  output logic             output_IRWrite,
  output logic             output_MemRead,
  output logic             output_MemWrite,
  output logic             output_IorD,
  output logic             output_RegWrite,
  output logic             output_MemtoReg,
  output logic             output_halted,
  output logic             output_illegal,
  output logic [3:0]       output_state,
  output logic [CNT_W-1:0] output_instr_count
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StAluWb   = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StHalt    = 4'd11,
    StIllegal = 4'd12
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [1:0] SrcAPc = 2'b00;
  localparam logic [1:0] SrcAA  = 2'b10;
  localparam logic [1:0] SrcBB  = 2'b00;
  localparam logic [1:0] SrcB2  = 2'b01;
  localparam logic [1:0] SrcBImm = 2'b10;

  state_e state_q, state_d;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    output_ALUOp    = AluAdd;
    output_ALUSrcA  = SrcAPc;
    output_ALUSrcB  = SrcBB;
    output_PCSrc    = 1'b0;
    output_PCWrite  = 1'b0;
    output_IRWrite  = 1'b0;
    output_MemRead  = 1'b0;
    output_MemWrite = 1'b0;
    output_IorD     = 1'b0;
    output_RegWrite = 1'b0;
    output_MemtoReg = 1'b0;
    output_halted   = 1'b0;
    output_illegal  = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        // PC <= PC + 2 and IR load happen together on the ready cycle.
        output_MemRead = 1'b1;
        output_ALUSrcB = SrcB2;
        output_IRWrite = input_mem_ready;
        output_PCWrite = input_mem_ready;
        if (input_mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculative branch target computed into ALUOut_sr.
        output_ALUSrcB = SrcBImm;
        if (input_opcode == HALT_OPCODE) begin
          state_d = StHalt;
        end else begin
          case (input_opcode)
            4'h0, 4'h1, 4'h2, 4'h3: state_d = StExecR;
            4'h4:                   state_d = StExecI;
            4'h5, 4'h6:             state_d = StMemAddr;
            4'h7, 4'h8:             state_d = StBranch;
            4'h9: begin
              state_d = StFetch;
              retire  = 1'b1;
            end
            default:                state_d = StIllegal;
          endcase
        end
      end
      StExecR: begin
        output_ALUSrcA = SrcAA;
        output_ALUSrcB = SrcBB;
        output_ALUOp   = input_opcode;
        state_d        = StAluWb;
      end
      StExecI: begin
        output_ALUSrcA = SrcAA;
        output_ALUSrcB = SrcBImm;
        state_d        = StAluWb;
      end
      StAluWb: begin
        output_RegWrite = 1'b1;
        state_d         = StFetch;
        retire          = 1'b1;
      end
      StMemAddr: begin
        output_ALUSrcA = SrcAA;
        output_ALUSrcB = SrcBImm;
        state_d        = (input_opcode == 4'h5) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        output_MemRead = 1'b1;
        output_IorD    = 1'b1;
        if (input_mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        output_RegWrite = 1'b1;
        output_MemtoReg = 1'b1;
        state_d         = StFetch;
        retire          = 1'b1;
      end
      StMemWr: begin
        output_MemWrite = 1'b1;
        output_IorD     = 1'b1;
        if (input_mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StBranch: begin
        output_ALUSrcA = SrcAA;
        output_ALUSrcB = SrcBB;
        output_ALUOp   = AluSub;
        output_PCSrc   = 1'b1;
        // BEQ takes on Zero, BNE on not-Zero.
        output_PCWrite = (input_opcode == 4'h7) ? input_Zero : ~input_Zero;
        state_d        = StFetch;
        retire         = 1'b1;
      end
      StHalt: output_halted = 1'b1;
      StIllegal: begin
        output_halted  = 1'b1;
        output_illegal = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign output_state = state_q;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] instr_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_q <= '0;
    end else if (retire) begin
      instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  assign output_instr_count = instr_count_q;
`else
  logic unused_retire;
  assign unused_retire      = retire;
  assign output_instr_count = '0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer. A cycle-level reference model pushes the
// expected output vector and count into a queue as each cycle's inputs are driven;
// the entry is popped and compared against the DUT on the falling edge.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  input_opcode = 4'h0;
  logic        input_Zero = 1'b0;
  logic        input_mem_ready = 1'b0;
  logic [3:0]  output_ALUOp;
  logic [1:0]  output_ALUSrcA;
  logic [1:0]  output_ALUSrcB;
  logic        output_PCSrc, output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite;
  logic        output_IorD, output_RegWrite, output_MemtoReg, output_halted, output_illegal;
  logic [3:0]  output_state;
  logic [3:0]  output_instr_count;

  calc_sequencer #(
    .CNT_W(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .input_opcode      (input_opcode),
    .input_Zero        (input_Zero),
    .input_mem_ready   (input_mem_ready),
    .output_ALUOp      (output_ALUOp),
    .output_ALUSrcA    (output_ALUSrcA),
    .output_ALUSrcB    (output_ALUSrcB),
    .output_PCSrc      (output_PCSrc),
    .output_PCWrite    (output_PCWrite),
    .output_IRWrite    (output_IRWrite),
    .output_MemRead    (output_MemRead),
    .output_MemWrite   (output_MemWrite),
    .output_IorD       (output_IorD),
    .output_RegWrite   (output_RegWrite),
    .output_MemtoReg   (output_MemtoReg),
    .output_halted     (output_halted),
    .output_illegal    (output_illegal),
    .output_state      (output_state),
    .output_instr_count(output_instr_count)
  );

  always #5 clk = ~clk;

  logic [21:0] dut_vec;
  assign dut_vec = {output_state, output_ALUOp, output_ALUSrcA, output_ALUSrcB, output_PCSrc,
                    output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite, output_IorD,
                    output_RegWrite, output_MemtoReg, output_halted, output_illegal};

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_state = 0;
  logic [3:0]  m_count = 4'd0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Expected {state, ALUOp, SrcA, SrcB, PCSrc, PCWrite, IRWrite, MemRead, MemWrite, IorD,
  // RegWrite, MemtoReg, halted, illegal} for a state and this cycle's inputs.
  function automatic logic [21:0] model_out(input int st, input logic [3:0] op, input logic z,
                                            input logic rdy);
    logic [3:0] aluop = 4'b0000;
    logic [1:0] srca = 2'b00, srcb = 2'b00;
    logic pcsrc = 0, pcw = 0, irw = 0, mr = 0, mw = 0, iord = 0, rw = 0, m2r = 0, h = 0, il = 0;
    case (st)
      1:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      2:  srcb = 2'b10;
      3:  begin srca = 2'b10; aluop = op; end
      4:  begin srca = 2'b10; srcb = 2'b10; end
      5:  rw = 1;
      6:  begin srca = 2'b10; srcb = 2'b10; end
      7:  begin mr = 1; iord = 1; end
      8:  begin rw = 1; m2r = 1; end
      9:  begin mw = 1; iord = 1; end
      10: begin srca = 2'b10; aluop = 4'b0001; pcsrc = 1; pcw = (op == 4'h7) ? z : !z; end
      11: h = 1;
      12: begin h = 1; il = 1; end
      default: ;
    endcase
    return {4'(st), aluop, srca, srcb, pcsrc, pcw, irw, mr, mw, iord, rw, m2r, h, il};
  endfunction

  task automatic model_step(input logic [3:0] op, input logic rdy);
    int   n = m_state;
    logic ret = 1'b0;
    case (m_state)
      0: n = 1;
      1: n = rdy ? 2 : 1;
      2: begin
        if (op == 4'hF)      n = 11;
        else if (op <= 4'h3) n = 3;
        else if (op == 4'h4) n = 4;
        else if (op == 4'h5 || op == 4'h6) n = 6;
        else if (op == 4'h7 || op == 4'h8) n = 10;
        else if (op == 4'h9) begin n = 1; ret = 1; end
        else n = 12;
      end
      3, 4: n = 5;
      5, 8, 10: begin n = 1; ret = 1; end
      6: n = (op == 4'h5) ? 7 : 9;
      7: n = rdy ? 8 : 7;
      9: if (rdy) begin n = 1; ret = 1; end
      default: ;
    endcase
    m_state = n;
`ifdef INSTR_COUNT_EN
    if (ret) m_count = m_count + 4'd1;
`else
    if (ret) m_count = 4'd0;
`endif
  endtask

  // Called just after a rising edge; drives one cycle and scores it.
  task automatic cycle(input logic [3:0] op, input logic z, input logic rdy);
    logic [31:0] e;
    input_opcode    = op;
    input_Zero      = z;
    input_mem_ready = rdy;
    exp_q.push_back({6'd0, m_count, model_out(m_state, op, z, rdy)});
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("outs st=%0d op=%0h", m_state, op), {10'd0, dut_vec}, {10'd0, e[21:0]});
    check($sformatf("count st=%0d", m_state), {28'd0, output_instr_count}, {28'd0, e[25:22]});
    model_step(op, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic z, input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(op, z, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset outs", {10'd0, dut_vec}, 32'd0);
    check("reset count", {28'd0, output_instr_count}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_state = 0;
    m_count = 4'd0;
  endtask

  initial begin
    logic [3:0] op;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // R-type ADD then SUB/AND/OR and ADDI, all with ready=1.
    run(4'h0, 1'b0, 1'b1, 5);
    for (int k = 1; k <= 4; k++) run(4'(k), 1'b0, 1'b1, 4);

    // LW with FETCH wait and three wait cycles in MEM_RD.
    run(4'h5, 1'b0, 1'b0, 2);
    run(4'h5, 1'b0, 1'b1, 3);
    run(4'h5, 1'b0, 1'b0, 3);
    run(4'h5, 1'b0, 1'b1, 2);

    // SW with one wait cycle, then all four branch flavours.
    run(4'h6, 1'b0, 1'b1, 3);
    run(4'h6, 1'b0, 1'b0, 1);
    run(4'h6, 1'b0, 1'b1, 1);
    for (int k = 0; k < 4; k++) run((k < 2) ? 4'h7 : 4'h8, k[0], 1'b1, 3);

    // Random legal traffic; opcode changes only while fetching.
    op = 4'h9;
    for (int i = 0; i < 300; i++) begin
      if (m_state == 1) op = 4'($urandom_range(0, 9));
      cycle(op, 1'($urandom), 1'($urandom));
    end

    // HALT is sticky and never requests memory.
    run(4'h9, 1'b0, 1'b1, 1);
    while (m_state != 1) cycle(4'h9, 1'b0, 1'b1);
    run(4'hF, 1'b0, 1'b1, 12);
    do_reset();
    run(4'hB, 1'b0, 1'b1, 6);

    // Reset asserted mid-MEM_WR clears outputs before the next edge.
    do_reset();
    run(4'h6, 1'b0, 1'b1, 4);
    run(4'h6, 1'b0, 1'b0, 1);
    check("memwr before reset", {31'd0, output_MemWrite}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async reset state", {28'd0, output_state}, 32'd0);
    check("async reset memwrite", {31'd0, output_MemWrite}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_state = 0;
    m_count = 4'd0;
    run(4'h6, 1'b0, 1'b1, 2);

    // 16 NOPs: count reaches 15 then wraps to 0 when the counter is built.
    do_reset();
    run(4'h9, 1'b0, 1'b1, 1);
    run(4'h9, 1'b0, 1'b1, 32);
    run(4'h9, 1'b0, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
